// File: rtl/execute_branch_ctrl_pkg.sv
// Shared encodings for the execute-stage branch controller: RV32I opcodes, branch funct3,
// 2-bit predictor counter states and ALU operation codes.
package execute_branch_ctrl_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

    localparam logic [2:0] FNC_BEQ  = 3'b000;
    localparam logic [2:0] FNC_BNE  = 3'b001;
    localparam logic [2:0] FNC_BLT  = 3'b100;
    localparam logic [2:0] FNC_BGE  = 3'b101;
    localparam logic [2:0] FNC_BLTU = 3'b110;
    localparam logic [2:0] FNC_BGEU = 3'b111;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } bht_ctr_e;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_SLTU   = 4'd9,
        ALU_COPY_B = 4'd10
    } alu_op_e;

    function automatic int bht_idx_w(input int entries);
        return $clog2(entries);
    endfunction

    // Saturating 2-bit counter step: 00 and 11 are sticky ends, never wrap.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != CTR_ST)
            nxt = ctr + 2'd1;
        else if (!taken && ctr != CTR_SNT)
            nxt = ctr - 2'd1;
        return nxt;
    endfunction

    // Register-register and register-immediate arithmetic share funct3 decoding;
    // only the R form turns funct7[5] into SUB.
    function automatic alu_op_e alu_from_funct(input logic [2:0] funct3,
                                               input logic       funct7_b5,
                                               input logic       is_imm);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (funct7_b5 && !is_imm) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/execute_branch_ctrl_bht.sv
// Branch history table of 2-bit saturating counters: one combinational read port for
// fetch and one registered update port for resolving branches.
module bht_2bit
    import execute_branch_ctrl_pkg::*;
#(
    parameter int         ENTRIES = 64,
    parameter logic [1:0] INIT    = CTR_WNT,
    localparam int        IW      = bht_idx_w(ENTRIES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] rd_idx,
    output logic [1:0]    rd_ctr,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic          wr_taken
);

    logic [1:0] ctr_q [ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr_q[i] <= INIT;
        end else if (wr_en) begin
            ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr_taken);
        end
    end

    // Reads the registered state, so a same-index update this cycle is not visible yet.
    assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/execute_branch_ctrl.sv
// RV32I execute-stage control: operand/ALU select decode, branch and jump resolution,
// fetch redirect with a multi-cycle squash window, 2-bit predictor and perf counters.
module execute_branch_ctrl
    import execute_branch_ctrl_pkg::*;
#(
    parameter int         BHT_ENTRIES  = 64,
    parameter logic [1:0] CTR_INIT     = 2'b01,
    parameter int         FLUSH_CYCLES = 1,
    parameter bit         PRED_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        fetch_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic [31:0] ex_instruction,
    input  logic [31:0] ex_pc,
    input  logic        ex_pred_taken,
    input  logic        less_than,
    input  logic        equal,
    input  logic [31:0] alu_result,
    output logic [3:0]  alu_select,
    output logic        a_select,
    output logic        b_select,
    output logic        unsigned_compare,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int         IW          = bht_idx_w(BHT_ENTRIES);
    localparam logic [1:0] FLUSH_EXTRA = 2'(FLUSH_CYCLES - 1);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    alu_op_e    alu_op;

    logic       is_jal;
    logic       is_jalr;
    logic       is_cond_branch;
    logic       taken;
    logic       pred_eff;
    logic       mispredict;
    logic       resolve;

    logic [1:0] flush_cnt_q;
    logic       flush_busy;
    logic [1:0] bht_rd_ctr;
    logic       bht_wr_en;

    assign opcode    = ex_instruction[6:0];
    assign funct3    = ex_instruction[14:12];
    assign funct7_b5 = ex_instruction[30];

    // Operand and ALU selects are pure decode, independent of valid/stall/flush.
    always_comb begin
        alu_op   = ALU_ADD;
        a_select = 1'b0;
        b_select = 1'b0;
        case (opcode)
            OPC_LUI: begin
                a_select = 1'b1;
                b_select = 1'b1;
                alu_op   = ALU_COPY_B;
            end
            OPC_AUIPC, OPC_JAL, OPC_BRANCH: begin
                a_select = 1'b1;
                b_select = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_STORE: begin
                b_select = 1'b1;
            end
            OPC_ARI_ITYPE: begin
                b_select = 1'b1;
                alu_op   = alu_from_funct(funct3, funct7_b5, 1'b1);
            end
            OPC_ARI_RTYPE: begin
                alu_op   = alu_from_funct(funct3, funct7_b5, 1'b0);
            end
            default: ;
        endcase
    end

    assign alu_select       = alu_op;
    assign unsigned_compare = funct3[1];

    assign is_jal         = (opcode == OPC_JAL);
    assign is_jalr        = (opcode == OPC_JALR);
    assign is_cond_branch = (opcode == OPC_BRANCH) && (funct3[2:1] != 2'b01);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            FNC_BEQ:            taken = equal;
            FNC_BNE:            taken = !equal;
            FNC_BLT, FNC_BLTU:  taken = less_than;
            FNC_BGE, FNC_BGEU:  taken = !less_than;
            default:            taken = 1'b0;
        endcase
    end

    // In static mode the carried prediction is meaningless; every taken branch mispredicts.
    assign pred_eff   = PRED_EN ? ex_pred_taken : 1'b0;
    assign mispredict = is_cond_branch && (taken != pred_eff);

    assign flush_busy = (flush_cnt_q != 2'd0);
    assign resolve    = ex_valid && !ex_stall && !flush_busy && !rst;
    assign redirect   = resolve && (is_jal || is_jalr || mispredict);
    assign flush      = redirect || flush_busy;

    always_comb begin
        redirect_pc = 32'd0;
        if (!rst) begin
            if (is_jalr)
                redirect_pc = {alu_result[31:1], 1'b0};
            else if (is_jal || (is_cond_branch && taken))
                redirect_pc = alu_result;
            else
                redirect_pc = ex_pc + 32'd4;
        end
    end

    // Redirect cycle itself is the first squash cycle; the counter covers the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flush_cnt_q <= 2'd0;
        else if (redirect)
            flush_cnt_q <= FLUSH_EXTRA;
        else if (flush_busy)
            flush_cnt_q <= flush_cnt_q - 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count     <= 32'd0;
            mispredict_count <= 32'd0;
        end else if (resolve && is_cond_branch) begin
            if (branch_count != 32'hFFFF_FFFF)
                branch_count <= branch_count + 32'd1;
            if (mispredict && mispredict_count != 32'hFFFF_FFFF)
                mispredict_count <= mispredict_count + 32'd1;
        end
    end

    assign bht_wr_en = resolve && is_cond_branch;

    generate
        if (PRED_EN) begin : g_bht
            bht_2bit #(
                .ENTRIES (BHT_ENTRIES),
                .INIT    (CTR_INIT)
            ) u_bht (
                .clk      (clk),
                .rst      (rst),
                .rd_idx   (fetch_pc[IW+1:2]),
                .rd_ctr   (bht_rd_ctr),
                .wr_en    (bht_wr_en),
                .wr_idx   (ex_pc[IW+1:2]),
                .wr_taken (taken)
            );
            assign fetch_pred_taken = bht_rd_ctr[1];
        end else begin : g_static
            assign bht_rd_ctr       = CTR_INIT;
            assign fetch_pred_taken = 1'b0;
        end
    endgenerate

    logic unused_ok;
    assign unused_ok = ^{fetch_pc, ex_pred_taken, ex_instruction, bht_rd_ctr, bht_wr_en};

endmodule

// File: tb/tb_execute_branch_ctrl.sv
// Directed bench for execute_branch_ctrl: three instances (default, 3-cycle flush,
// static not-taken) share one stimulus stream; each section resets and checks one of them.
module tb_execute_branch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        ex_valid;
    logic        ex_stall;
    logic [31:0] ex_instruction;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic        less_than;
    logic        equal;
    logic [31:0] alu_result;

    logic        fetch_pred_a, fetch_pred_b, fetch_pred_c;
    logic [3:0]  alu_sel_a, alu_sel_b, alu_sel_c;
    logic        a_sel_a, a_sel_b, a_sel_c;
    logic        b_sel_a, b_sel_b, b_sel_c;
    logic        ucmp_a, ucmp_b, ucmp_c;
    logic        redirect_a, redirect_b, redirect_c;
    logic [31:0] redirect_pc_a, redirect_pc_b, redirect_pc_c;
    logic        flush_a, flush_b, flush_c;
    logic [31:0] br_cnt_a, br_cnt_b, br_cnt_c;
    logic [31:0] mp_cnt_a, mp_cnt_b, mp_cnt_c;

    int checks = 0;
    int errors = 0;

    execute_branch_ctrl #(.BHT_ENTRIES(64), .CTR_INIT(2'b01), .FLUSH_CYCLES(1), .PRED_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_pred_taken(fetch_pred_a),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_instruction(ex_instruction), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken), .less_than(less_than), .equal(equal), .alu_result(alu_result),
        .alu_select(alu_sel_a), .a_select(a_sel_a), .b_select(b_sel_a), .unsigned_compare(ucmp_a),
        .redirect(redirect_a), .redirect_pc(redirect_pc_a), .flush(flush_a),
        .branch_count(br_cnt_a), .mispredict_count(mp_cnt_a));

    execute_branch_ctrl #(.BHT_ENTRIES(64), .CTR_INIT(2'b01), .FLUSH_CYCLES(3), .PRED_EN(1'b1)) dut_b (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_pred_taken(fetch_pred_b),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_instruction(ex_instruction), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken), .less_than(less_than), .equal(equal), .alu_result(alu_result),
        .alu_select(alu_sel_b), .a_select(a_sel_b), .b_select(b_sel_b), .unsigned_compare(ucmp_b),
        .redirect(redirect_b), .redirect_pc(redirect_pc_b), .flush(flush_b),
        .branch_count(br_cnt_b), .mispredict_count(mp_cnt_b));

    execute_branch_ctrl #(.BHT_ENTRIES(64), .CTR_INIT(2'b01), .FLUSH_CYCLES(1), .PRED_EN(1'b0)) dut_c (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_pred_taken(fetch_pred_c),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_instruction(ex_instruction), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken), .less_than(less_than), .equal(equal), .alu_result(alu_result),
        .alu_select(alu_sel_c), .a_select(a_sel_c), .b_select(b_sel_c), .unsigned_compare(ucmp_c),
        .redirect(redirect_c), .redirect_pc(redirect_pc_c), .flush(flush_c),
        .branch_count(br_cnt_c), .mispredict_count(mp_cnt_c));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // checking
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // instruction builders
    function automatic logic [31:0] mk_branch(input logic [2:0] f3);
        return {7'd0, 5'd2, 5'd1, f3, 5'd0, 7'b1100011};
    endfunction
    function automatic logic [31:0] mk_jalr();
        return {12'd0, 5'd1, 3'd0, 5'd1, 7'b1100111};
    endfunction
    function automatic logic [31:0] mk_jal();
        return {20'd0, 5'd1, 7'b1101111};
    endfunction
    function automatic logic [31:0] mk_rtype(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction
    function automatic logic [31:0] mk_itype(input logic [11:0] imm, input logic [2:0] f3);
        return {imm, 5'd1, f3, 5'd3, 7'b0010011};
    endfunction

    // drivers
    task automatic set_ex(input logic v, input logic st, input logic [31:0] ins,
                          input logic [31:0] pc, input logic pr, input logic lt,
                          input logic eq, input logic [31:0] alu);
        ex_valid       = v;
        ex_stall       = st;
        ex_instruction = ins;
        ex_pc          = pc;
        ex_pred_taken  = pr;
        less_than      = lt;
        equal          = eq;
        alu_result     = alu;
    endtask

    task automatic idle();
        set_ex(1'b0, 1'b0, 32'h0000_0013, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        next_cycle();
    endtask

    typedef struct {
        logic [2:0] f3;
        logic       lt;
        logic       eq;
        logic       exp_taken;
        logic       counted;
    } br_vec_t;

    br_vec_t br_tab [8];

    initial begin
        rst      = 1'b0;
        fetch_pc = 32'h0000_0100;
        idle();

        // async reset pulse mid-cycle, with a JAL presented that must not redirect
        #7;
        set_ex(1'b1, 1'b0, mk_jal(), 32'h40, 1'b0, 1'b0, 1'b0, 32'h80);
        rst = 1'b1;
        #1;
        check("rst_redirect", redirect_a, 1'b0);
        check("rst_flush", flush_a, 1'b0);
        check("rst_redirect_pc", redirect_pc_a, 32'd0);
        check("rst_br_cnt", br_cnt_a, 32'd0);
        check("rst_mp_cnt", mp_cnt_a, 32'd0);
        check("rst_fetch_pred", fetch_pred_a, 1'b0);
        idle();
        #6;
        rst = 1'b0;
        next_cycle();

        // pure decode, no side effects with ex_valid low
        set_ex(1'b0, 1'b0, mk_rtype(7'b0100000, 3'b000), 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("dec_sub_alu", alu_sel_a, 4'd1);
        check("dec_sub_ab", {a_sel_a, b_sel_a}, 2'b00);
        ex_instruction = mk_itype(12'b0100000_00011, 3'b101);
        #1;
        check("dec_srai_alu", alu_sel_a, 4'd7);
        check("dec_srai_ab", {a_sel_a, b_sel_a}, 2'b01);
        ex_instruction = mk_itype(12'h0ff, 3'b000);
        #1;
        check("dec_addi_alu", alu_sel_a, 4'd0);
        ex_instruction = {20'h12345, 5'd3, 7'b0110111};
        #1;
        check("dec_lui_alu", alu_sel_a, 4'd10);
        check("dec_lui_ab", {a_sel_a, b_sel_a}, 2'b11);
        ex_instruction = {7'd0, 5'd2, 5'd1, 3'b010, 5'd0, 7'b0100011};
        #1;
        check("dec_store_ab", {a_sel_a, b_sel_a}, 2'b01);
        ex_instruction = mk_rtype(7'd0, 3'b011);
        #1;
        check("dec_sltu_alu", alu_sel_a, 4'd9);
        next_cycle();

        // BEQ mispredicted taken at 0x100
        fetch_pc = 32'h100;
        set_ex(1'b1, 1'b0, mk_branch(3'b000), 32'h100, 1'b0, 1'b0, 1'b1, 32'h140);
        @(negedge clk);
        check("beq_redirect", redirect_a, 1'b1);
        check("beq_redirect_pc", redirect_pc_a, 32'h140);
        check("beq_flush", flush_a, 1'b1);
        check("beq_fetch_pre", fetch_pred_a, 1'b0);
        check("beq_ab", {a_sel_a, b_sel_a}, 2'b11);
        check("beq_alu", alu_sel_a, 4'd0);
        check("beq_ucmp", ucmp_a, 1'b0);
        next_cycle();
        idle();
        @(negedge clk);
        check("beq_flush_done", flush_a, 1'b0);
        check("beq_br_cnt", br_cnt_a, 32'd1);
        check("beq_mp_cnt", mp_cnt_a, 32'd1);
        check("beq_ctr_10", fetch_pred_a, 1'b1);
        next_cycle();

        // three correctly predicted taken: 10 -> 11, then stays 11
        for (int i = 0; i < 3; i++) begin
            set_ex(1'b1, 1'b0, mk_branch(3'b000), 32'h100, 1'b1, 1'b0, 1'b1, 32'h140);
            @(negedge clk);
            check("beq_pred_ok_noredir", redirect_a, 1'b0);
            next_cycle();
        end
        // not-taken while predicted taken: 11 -> 10
        set_ex(1'b1, 1'b0, mk_branch(3'b000), 32'h100, 1'b1, 1'b0, 1'b0, 32'h140);
        @(negedge clk);
        check("beq_nt_redirect", redirect_a, 1'b1);
        check("beq_nt_redirect_pc", redirect_pc_a, 32'h104);
        next_cycle();
        idle();
        @(negedge clk);
        check("sat_br_cnt", br_cnt_a, 32'd5);
        check("sat_mp_cnt", mp_cnt_a, 32'd2);
        check("sat_ctr_10", fetch_pred_a, 1'b1);
        next_cycle();
        // second not-taken: 10 -> 01 (only reachable with msb 1 above if it saturated at 11)
        set_ex(1'b1, 1'b0, mk_branch(3'b000), 32'h100, 1'b1, 1'b0, 1'b0, 32'h140);
        next_cycle();
        idle();
        @(negedge clk);
        check("sat_ctr_01", fetch_pred_a, 1'b0);
        check("sat_mp_cnt2", mp_cnt_a, 32'd3);
        next_cycle();

        // branch condition table, predicted not-taken so redirect == taken
        do_reset();
        br_tab[0] = '{3'b000, 1'b0, 1'b1, 1'b1, 1'b1};
        br_tab[1] = '{3'b001, 1'b0, 1'b1, 1'b0, 1'b1};
        br_tab[2] = '{3'b100, 1'b1, 1'b0, 1'b1, 1'b1};
        br_tab[3] = '{3'b101, 1'b1, 1'b0, 1'b0, 1'b1};
        br_tab[4] = '{3'b110, 1'b0, 1'b0, 1'b0, 1'b1};
        br_tab[5] = '{3'b111, 1'b0, 1'b0, 1'b1, 1'b1};
        br_tab[6] = '{3'b010, 1'b1, 1'b1, 1'b0, 1'b0};
        br_tab[7] = '{3'b011, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            set_ex(1'b1, 1'b0, mk_branch(br_tab[i].f3), 32'h300, 1'b0,
                   br_tab[i].lt, br_tab[i].eq, 32'h380);
            @(negedge clk);
            check($sformatf("tab%0d_redirect", i), redirect_a, br_tab[i].exp_taken);
            if (br_tab[i].exp_taken)
                check($sformatf("tab%0d_pc", i), redirect_pc_a, 32'h380);
            else
                check($sformatf("tab%0d_pc", i), redirect_pc_a, 32'h304);
            check($sformatf("tab%0d_ucmp", i), ucmp_a, br_tab[i].f3[1]);
            next_cycle();
        end
        idle();
        @(negedge clk);
        check("tab_br_cnt", br_cnt_a, 32'd6);
        check("tab_mp_cnt", mp_cnt_a, 32'd3);
        next_cycle();

        // three-cycle squash after JALR; a BNE inside the window is ignored
        do_reset();
        set_ex(1'b1, 1'b0, mk_jalr(), 32'h200, 1'b0, 1'b0, 1'b0, 32'h203);
        @(negedge clk);
        check("jalr_redirect", redirect_b, 1'b1);
        check("jalr_redirect_pc", redirect_pc_b, 32'h202);
        check("jalr_flush1", flush_b, 1'b1);
        check("jalr_ab", {a_sel_b, b_sel_b}, 2'b01);
        next_cycle();
        for (int i = 2; i <= 3; i++) begin
            set_ex(1'b1, 1'b0, mk_branch(3'b001), 32'h400, 1'b0, 1'b0, 1'b0, 32'h480);
            @(negedge clk);
            check($sformatf("win%0d_flush", i), flush_b, 1'b1);
            check($sformatf("win%0d_noredir", i), redirect_b, 1'b0);
            next_cycle();
        end
        idle();
        @(negedge clk);
        check("win_end_flush", flush_b, 1'b0);
        check("win_end_redirect", redirect_b, 1'b0);
        check("win_br_cnt", br_cnt_b, 32'd0);
        next_cycle();

        // reset during the squash window drops flush immediately
        set_ex(1'b1, 1'b0, mk_jalr(), 32'h200, 1'b0, 1'b0, 1'b0, 32'h203);
        next_cycle();
        idle();
        @(negedge clk);
        check("midflush_busy", flush_b, 1'b1);
        rst = 1'b1;
        #1;
        check("midflush_rst", flush_b, 1'b0);
        #2;
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        check("midflush_after", flush_b, 1'b0);
        next_cycle();

        // stall holds off resolution of a mispredicting BLT
        do_reset();
        fetch_pc = 32'h500;
        for (int i = 0; i < 4; i++) begin
            set_ex(1'b1, 1'b1, mk_branch(3'b100), 32'h500, 1'b0, 1'b1, 1'b0, 32'h540);
            @(negedge clk);
            check($sformatf("stall%0d_redirect", i), redirect_a, 1'b0);
            check($sformatf("stall%0d_flush", i), flush_a, 1'b0);
            check($sformatf("stall%0d_ab", i), {a_sel_a, b_sel_a}, 2'b11);
            next_cycle();
        end
        ex_stall = 1'b0;
        @(negedge clk);
        check("stall_pred_untouched", fetch_pred_a, 1'b0);
        check("stall_br_cnt0", br_cnt_a, 32'd0);
        check("unstall_redirect", redirect_a, 1'b1);
        check("unstall_redirect_pc", redirect_pc_a, 32'h540);
        next_cycle();
        idle();
        @(negedge clk);
        check("unstall_br_cnt", br_cnt_a, 32'd1);
        check("unstall_mp_cnt", mp_cnt_a, 32'd1);
        check("unstall_ctr_10", fetch_pred_a, 1'b1);
        next_cycle();

        // static not-taken mode: prediction input ignored, no table
        do_reset();
        fetch_pc = 32'h600;
        set_ex(1'b1, 1'b0, mk_branch(3'b111), 32'h600, 1'b1, 1'b0, 1'b0, 32'h640);
        @(negedge clk);
        check("static_redirect", redirect_c, 1'b1);
        check("static_redirect_pc", redirect_pc_c, 32'h640);
        check("static_fetch_pred", fetch_pred_c, 1'b0);
        check("dyn_pred_ok_noredir", redirect_a, 1'b0);
        next_cycle();
        idle();
        @(negedge clk);
        check("static_fetch_pred2", fetch_pred_c, 1'b0);
        check("static_br_cnt", br_cnt_c, 32'd1);
        check("static_mp_cnt", mp_cnt_c, 32'd1);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout: got 0x00000000 expected 0x00000001");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
